fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter WAIT_LIMIT, default 16, SHALL set the max cycles spent in WAIT before fault (range 1..255).
REQ-002 Port clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port clear  input  1  SHALL be the asynchronous, active-low reset (0 = reset).
REQ-004 Port run  input  1  SHALL permit new fetches while high.
REQ-005 Port flush  input  1  SHALL discard the in-flight or held instruction (branch redirect).
REQ-006 Port pc_in  input  32  SHALL be the current PC register value.
REQ-007 Port inc_pc  output  1  SHALL be the IncPC strobe to the PC register.
REQ-008 Port mem_addr  output  32  SHALL be the registered fetch address.
REQ-009 Port mem_read  output  1  SHALL be the memory read request.
REQ-010 Port mem_ready  input  1  SHALL indicate mem_data is valid this cycle.
REQ-011 Port mem_data  input  32  SHALL be the memory read data.
REQ-012 Port ir_out  output  32  SHALL be the fetched instruction word.
REQ-013 Port ir_valid  output  1  SHALL mark ir_out as holding an unconsumed instruction.
REQ-014 Port ir_ack  input  1  SHALL be the downstream consume strobe for ir_out.
REQ-015 Port fault  output  1  SHALL flag a memory timeout.
REQ-016 Port fetch_count  output  16  SHALL count completed fetches.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, HOLD, FAULT; all outputs SHALL be registered.
REQ-018 IDLE: run=1 -> REQ; else stay.
REQ-019 REQ (exactly 1 cycle): mem_addr <= pc_in, mem_read <= 1, wait counter <= 0, -> WAIT.
REQ-020 WAIT: mem_read held 1, mem_addr stable; counter +1 per cycle without mem_ready.
REQ-021 WAIT with mem_ready=1 and no discard pending: ir_out <= mem_data, ir_valid <= 1, inc_pc <= 1, fetch_count +1, mem_read <= 0, -> HOLD.
REQ-022 inc_pc SHALL be a 1-cycle pulse, exactly one per accepted instruction, never otherwise.
REQ-023 fetch_count SHALL wrap 16'hFFFF -> 0.
REQ-024 HOLD: ir_valid held 1, ir_out stable until ir_ack=1; on ir_ack: ir_valid <= 0, -> REQ if run=1 else IDLE.
REQ-025 Next REQ SHALL occur no earlier than 1 cycle after the inc_pc pulse, so mem_addr samples the incremented PC.
REQ-026 flush in REQ or WAIT SHALL set discard-pending; the matching mem_ready SHALL NOT load ir_out, pulse inc_pc, or count; -> REQ (run=1) or IDLE.
REQ-027 flush in HOLD SHALL clear ir_valid, -> REQ (run=1) or IDLE; flush wins over simultaneous ir_ack.
REQ-028 flush in IDLE or FAULT SHALL have no effect.
REQ-029 run=0 SHALL NOT abort a fetch in progress; the FSM returns to IDLE after the current instruction is acked or discarded.
REQ-030 Counter reaching WAIT_LIMIT without mem_ready SHALL: mem_read <= 0, fault <= 1, -> FAULT.
REQ-031 mem_ready in the same cycle as the limit SHALL be accepted (ready wins, no fault).
REQ-032 FAULT SHALL be terminal until reset; mem_read, inc_pc, ir_valid = 0; fault = 1.
REQ-033 mem_ready outside WAIT SHALL be ignored.

Reset
REQ-034 clear=0 SHALL immediately, without clock, force state IDLE, mem_addr=0, mem_read=0, inc_pc=0, ir_out=0, ir_valid=0, fault=0, fetch_count=0, discard-pending=0, wait counter=0.
REQ-035 Reset asserted mid-fetch SHALL abandon the fetch with no inc_pc pulse; a late mem_ready after release SHALL be ignored (REQ-033).
REQ-036 After clear rises, the first REQ SHALL occur no earlier than the second rising edge with run=1.

Verification
REQ-037 pc_in=0x10, run=1, mem_ready 2 cycles after mem_read with mem_data=0xDEADBEEF -> mem_addr=0x10, ir_out=0xDEADBEEF, ir_valid=1, one inc_pc pulse, fetch_count=1.
REQ-038 Back-to-back: ir_ack 1 cycle after ir_valid, pc_in increments 0x10->0x11 -> second mem_addr=0x11, exactly two inc_pc pulses total.
REQ-039 flush in WAIT, then mem_ready with 0x12345678 -> ir_valid stays 0, no inc_pc, fetch_count unchanged, new REQ issued.
REQ-040 WAIT_LIMIT=4, mem_ready never asserted -> fault=1 and mem_read=0 after 4 WAIT cycles; run/flush/mem_ready then produce no change.
REQ-041 clear pulsed low between clock edges in WAIT -> all outputs zero immediately; no inc_pc; normal fetch resumes after release.
REQ-042 fetch_count preset to 0xFFFF via 65535 fetches, one more fetch -> fetch_count=0x0000.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one memory read per instruction, holds the
// fetched word for the decoder, supports branch-redirect discards and memory timeouts.
module fetch_sequencer #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic        flush,
    input  logic [31:0] pc_in,
    output logic        inc_pc,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    output logic [31:0] ir_out,
    output logic        ir_valid,
    input  logic        ir_ack,
    output logic        fault,
    output logic [15:0] fetch_count
);

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned COUNT_W = 16;
    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t               state;
    state_t               state_next;
    state_t               resume;
    logic                 discard;
    logic                 discard_next;
    logic [CNT_W-1:0]     wait_cnt;
    logic [CNT_W-1:0]     wait_cnt_next;
    logic [ADDR_W-1:0]    mem_addr_next;
    logic                 mem_read_next;
    logic                 inc_pc_next;
    logic [DATA_W-1:0]    ir_out_next;
    logic                 ir_valid_next;
    logic                 fault_next;
    logic [COUNT_W-1:0]   fetch_count_next;

    // State and every output are registered here; all next values come from the block below.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= S_IDLE;
            discard     <= 1'b0;
            wait_cnt    <= '0;
            mem_addr    <= '0;
            mem_read    <= 1'b0;
            inc_pc      <= 1'b0;
            ir_out      <= '0;
            ir_valid    <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_next;
            discard     <= discard_next;
            wait_cnt    <= wait_cnt_next;
            mem_addr    <= mem_addr_next;
            mem_read    <= mem_read_next;
            inc_pc      <= inc_pc_next;
            ir_out      <= ir_out_next;
            ir_valid    <= ir_valid_next;
            fault       <= fault_next;
            fetch_count <= fetch_count_next;
        end
    end

    // Where to go once the current instruction is consumed or dropped.
    always_comb begin
        resume = run ? S_REQ : S_IDLE;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next       = state;
        discard_next     = discard;
        wait_cnt_next    = wait_cnt;
        mem_addr_next    = mem_addr;
        mem_read_next    = mem_read;
        inc_pc_next      = 1'b0;
        ir_out_next      = ir_out;
        ir_valid_next    = ir_valid;
        fault_next       = fault;
        fetch_count_next = fetch_count;

        case (state)
            S_IDLE: begin
                if (run) begin
                    state_next = S_REQ;
                end
            end

            S_REQ: begin
                mem_addr_next = pc_in;
                mem_read_next = 1'b1;
                wait_cnt_next = '0;
                discard_next  = flush;
                state_next    = S_WAIT;
            end

            S_WAIT: begin
                if (mem_ready) begin
                    // Ready beats the timeout; a flush in this same cycle still discards.
                    mem_read_next = 1'b0;
                    discard_next  = 1'b0;
                    if (discard || flush) begin
                        state_next = resume;
                    end else begin
                        ir_out_next      = mem_data;
                        ir_valid_next    = 1'b1;
                        inc_pc_next      = 1'b1;
                        fetch_count_next = fetch_count + COUNT_W'(1);
                        state_next       = S_HOLD;
                    end
                end else if (wait_cnt == LAST_WAIT) begin
                    mem_read_next = 1'b0;
                    fault_next    = 1'b1;
                    discard_next  = 1'b0;
                    state_next    = S_FAULT;
                end else begin
                    wait_cnt_next = wait_cnt + CNT_W'(1);
                    if (flush) begin
                        discard_next = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                // Flush and ack leave the same way; flush only matters for intent.
                if (flush || ir_ack) begin
                    ir_valid_next = 1'b0;
                    state_next    = resume;
                end
            end

            S_FAULT: begin
                mem_read_next = 1'b0;
                ir_valid_next = 1'b0;
                fault_next    = 1'b1;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: fetched words are checked through a scoreboard
// queue, control outputs through immediate assertions at each step.
module tb_fetch_sequencer;

    localparam int unsigned LIMIT = 4;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        run = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] pc_in = '0;
    logic        inc_pc;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_data = '0;
    logic [31:0] ir_out;
    logic        ir_valid;
    logic        ir_ack = 1'b0;
    logic        fault;
    logic [15:0] fetch_count;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned inc_total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;
    logic        valid_prev = 1'b0;
    logic        inc_prev = 1'b0;

    always #5 clock = ~clock;

    fetch_sequencer #(.WAIT_LIMIT(LIMIT)) dut (
        .clock(clock),
        .clear(clear),
        .run(run),
        .flush(flush),
        .pc_in(pc_in),
        .inc_pc(inc_pc),
        .mem_addr(mem_addr),
        .mem_read(mem_read),
        .mem_ready(mem_ready),
        .mem_data(mem_data),
        .ir_out(ir_out),
        .ir_valid(ir_valid),
        .ir_ack(ir_ack),
        .fault(fault),
        .fetch_count(fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard pop on each new instruction, plus inc_pc pulse counting.
    always @(negedge clock) begin
        if (inc_pc) begin
            inc_total++;
            checks++;
            assert (!inc_prev) else begin
                errors++;
                $error("FAIL inc_pc_width observed=2+ cycles expected=1 cycle");
            end
        end
        if (ir_valid && !valid_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL sb_unexpected observed=%h expected=none", ir_out);
            end else begin
                sb_exp = exp_q.pop_front();
                assert (ir_out === sb_exp) else begin
                    errors++;
                    $error("FAIL sb_ir_out observed=%h expected=%h", ir_out, sb_exp);
                end
            end
        end
        valid_prev <= ir_valid;
        inc_prev   <= inc_pc;
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_read", 32'(mem_read), 32'h0);
        chk("rst_inc_pc", 32'(inc_pc), 32'h0);
        chk("rst_ir_out", ir_out, 32'h0);
        chk("rst_ir_valid", 32'(ir_valid), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_fetch_count", 32'(fetch_count), 32'h0);

        // Single fetch, ready two cycles after mem_read
        clear = 1'b1;
        run   = 1'b1;
        pc_in = 32'h10;
        tick();
        chk("first_edge_no_req", 32'(mem_read), 32'h0);
        tick();
        chk("f1_mem_read", 32'(mem_read), 32'h1);
        chk("f1_mem_addr", mem_addr, 32'h10);
        tick();
        chk("f1_wait_hold_read", 32'(mem_read), 32'h1);
        chk("f1_wait_addr_stable", mem_addr, 32'h10);
        mem_ready = 1'b1;
        mem_data  = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF);
        tick();
        mem_ready = 1'b0;
        chk("f1_ir_out", ir_out, 32'hDEADBEEF);
        chk("f1_ir_valid", 32'(ir_valid), 32'h1);
        chk("f1_inc_pc", 32'(inc_pc), 32'h1);
        chk("f1_fetch_count", 32'(fetch_count), 32'h1);
        chk("f1_read_drop", 32'(mem_read), 32'h0);
        pc_in = 32'h11;

        // Back-to-back: ack one cycle after ir_valid
        tick();
        chk("f1_inc_single", 32'(inc_pc), 32'h0);
        chk("f1_hold_valid", 32'(ir_valid), 32'h1);
        chk("f1_hold_ir", ir_out, 32'hDEADBEEF);
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        chk("f1_ack_valid", 32'(ir_valid), 32'h0);
        tick();
        chk("f2_mem_addr", mem_addr, 32'h11);
        chk("f2_mem_read", 32'(mem_read), 32'h1);
        mem_ready = 1'b1;
        mem_data  = 32'hCAFE0001;
        exp_q.push_back(32'hCAFE0001);
        tick();
        mem_ready = 1'b0;
        chk("f2_fetch_count", 32'(fetch_count), 32'h2);
        run    = 1'b0;
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        chk("f2_ack_valid", 32'(ir_valid), 32'h0);
        tick();
        chk("f2_idle_read", 32'(mem_read), 32'h0);
        chk("f2_inc_total", inc_total, 32'd2);

        // Flush in WAIT discards the returning word and reissues
        run   = 1'b1;
        pc_in = 32'h20;
        tick();
        tick();
        chk("f3_mem_addr", mem_addr, 32'h20);
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        mem_ready = 1'b1;
        mem_data  = 32'h12345678;
        tick();
        mem_ready = 1'b0;
        chk("f3_discard_valid", 32'(ir_valid), 32'h0);
        chk("f3_discard_inc", 32'(inc_pc), 32'h0);
        chk("f3_discard_count", 32'(fetch_count), 32'h2);
        chk("f3_discard_read", 32'(mem_read), 32'h0);
        tick();
        chk("f3_reissue_read", 32'(mem_read), 32'h1);
        mem_ready = 1'b1;
        mem_data  = 32'h0BADF00D;
        exp_q.push_back(32'h0BADF00D);
        tick();
        mem_ready = 1'b0;
        chk("f3_fetch_count", 32'(fetch_count), 32'h3);

        // Flush in HOLD beats a simultaneous ack; run low returns to IDLE
        flush  = 1'b1;
        ir_ack = 1'b1;
        run    = 1'b0;
        tick();
        flush  = 1'b0;
        ir_ack = 1'b0;
        chk("f3_hold_flush_valid", 32'(ir_valid), 32'h0);
        tick();
        chk("f3_idle_read", 32'(mem_read), 32'h0);
        chk("f3_inc_total", inc_total, 32'd3);

        // Ready on the last allowed WAIT cycle wins over timeout; run drop does not abort
        run   = 1'b1;
        pc_in = 32'h30;
        tick();
        tick();
        run = 1'b0;
        tick();
        tick();
        tick();
        chk("f4_limit_read", 32'(mem_read), 32'h1);
        chk("f4_limit_fault", 32'(fault), 32'h0);
        mem_ready = 1'b1;
        mem_data  = 32'h5A5A5A5A;
        exp_q.push_back(32'h5A5A5A5A);
        tick();
        mem_ready = 1'b0;
        chk("f4_no_fault", 32'(fault), 32'h0);
        chk("f4_valid", 32'(ir_valid), 32'h1);
        chk("f4_fetch_count", 32'(fetch_count), 32'h4);
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        tick();
        chk("f4_idle_read", 32'(mem_read), 32'h0);

        // Timeout after LIMIT WAIT cycles; FAULT is terminal
        run   = 1'b1;
        pc_in = 32'h40;
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("f5_pre_fault", 32'(fault), 32'h0);
        chk("f5_pre_read", 32'(mem_read), 32'h1);
        tick();
        chk("f5_fault", 32'(fault), 32'h1);
        chk("f5_read_drop", 32'(mem_read), 32'h0);
        flush     = 1'b1;
        mem_ready = 1'b1;
        mem_data  = 32'h77777777;
        tick();
        tick();
        flush     = 1'b0;
        mem_ready = 1'b0;
        chk("f5_fault_stuck", 32'(fault), 32'h1);
        chk("f5_fault_read", 32'(mem_read), 32'h0);
        chk("f5_fault_valid", 32'(ir_valid), 32'h0);
        chk("f5_fault_count", 32'(fetch_count), 32'h4);
        chk("f5_inc_total", inc_total, 32'd4);

        // Reset between edges clears fault; then reset mid-WAIT abandons the fetch
        #2;
        clear = 1'b0;
        #1;
        chk("r1_fault_clear", 32'(fault), 32'h0);
        clear = 1'b1;
        pc_in = 32'h50;
        tick();
        tick();
        chk("r2_wait_read", 32'(mem_read), 32'h1);
        #3;
        clear = 1'b0;
        #1;
        chk("r2_async_read", 32'(mem_read), 32'h0);
        chk("r2_async_addr", mem_addr, 32'h0);
        chk("r2_async_count", 32'(fetch_count), 32'h0);
        mem_ready = 1'b1;
        mem_data  = 32'h99999999;
        #1;
        clear = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("r2_late_ready_valid", 32'(ir_valid), 32'h0);
        chk("r2_late_ready_read", 32'(mem_read), 32'h0);
        tick();
        chk("r2_resume_read", 32'(mem_read), 32'h1);
        chk("r2_resume_addr", mem_addr, 32'h50);
        mem_ready = 1'b1;
        mem_data  = 32'h600D600D;
        exp_q.push_back(32'h600D600D);
        tick();
        mem_ready = 1'b0;
        run       = 1'b0;
        chk("r2_fetch_count", 32'(fetch_count), 32'h1);
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        tick();
        chk("r2_inc_total", inc_total, 32'd5);

        // fetch_count wrap: preset the counter, then one more fetch
        force dut.fetch_count = 16'hFFFF;
        tick();
        release dut.fetch_count;
        #1;
        chk("w_preset", 32'(fetch_count), 32'hFFFF);
        run   = 1'b1;
        pc_in = 32'h60;
        tick();
        tick();
        mem_ready = 1'b1;
        mem_data  = 32'h13572468;
        exp_q.push_back(32'h13572468);
        tick();
        mem_ready = 1'b0;
        run       = 1'b0;
        chk("w_wrap", 32'(fetch_count), 32'h0);
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        tick();
        chk("sb_drained", exp_q.size(), 32'd0);
        chk("w_inc_total", inc_total, 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
